// File: rtl/rs_pkg.sv
// rs_pkg: shared constants and branch geometry helpers for the convolutional deinterleaver.
package rs_pkg;
    localparam int INTLV_I     = 12;
    localparam int INTLV_M     = 17;
    localparam int DEINTLV_LAT = INTLV_M * INTLV_I * (INTLV_I - 1);
    localparam int RAM_DEPTH   = DEINTLV_LAT / 2;

    function automatic int branch_depth(input int j, input int i, input int m);
        return (i - 1 - j) * m;
    endfunction

    function automatic int branch_base(input int j, input int i, input int m);
        int s;
        s = 0;
        for (int k = 0; k < j; k++) s += branch_depth(k, i, m);
        return s;
    endfunction
endpackage

// File: rtl/deintlv_ram.sv
// deintlv_ram: simple dual-port RAM, synchronous write, registered read-first read.
module deintlv_ram #(
    parameter int DEPTH = 1122,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/conv_deinterleaver.sv
// conv_deinterleaver: Forney byte deinterleaver, branch j delayed by (I-1-j)*M bytes in one shared RAM.
// The pass-through branch byte is pipelined alongside the registered RAM read so all branches align.
module conv_deinterleaver
    import rs_pkg::*;
#(
    parameter int I  = INTLV_I,
    parameter int M  = INTLV_M,
    parameter int DW = 8
) (
    input  logic                 clk_out125M,
    input  logic                 sys_rst,
    input  logic [DW-1:0]        intlv_out_err,
    input  logic                 intlv_out_sync,
    output logic [DW-1:0]        deintlv_out,
    output logic                 deintlv_out_valid,
    output logic [$clog2(I)-1:0] deintlv_branch
);
    localparam int L     = M * I * (I - 1);
    localparam int DEPTH = L / 2;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = $clog2((I - 1) * M + 1);
    localparam int BW    = $clog2(I);
    localparam int FW    = $clog2(L + 1);

    logic [BW-1:0] r_br;
    logic [PW-1:0] r_ptr [I];
    logic [FW-1:0] r_fill;
    logic          r_vld;
    logic          r_pass;
    logic [DW-1:0] r_byte;
    logic [BW-1:0] r_branch;
    logic [AW-1:0] w_base [I];
    logic [PW-1:0] w_last [I];
    logic          w_pass;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_q;

    for (genvar g = 0; g < I; g++) begin : g_tab
        assign w_base[g] = AW'(branch_base(g, I, M));
        assign w_last[g] = PW'(branch_depth(g, I, M) - 1);
    end

    assign w_pass = r_br == BW'(I - 1);
    assign w_we   = intlv_out_sync && !w_pass;
    assign w_addr = w_pass ? '0 : w_base[r_br] + AW'(r_ptr[r_br]);

    deintlv_ram #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_ram (
        .clk     (clk_out125M),
        .i_we    (w_we),
        .i_waddr (w_addr),
        .i_wdata (intlv_out_err),
        .i_raddr (w_addr),
        .o_rdata (w_q)
    );

    // A sync drop clears everything the same way reset does, forcing a full refill.
    always_ff @(posedge clk_out125M or posedge sys_rst) begin
        if (sys_rst) begin
            r_br     <= '0;
            r_fill   <= '0;
            r_vld    <= 1'b0;
            r_pass   <= 1'b0;
            r_byte   <= '0;
            r_branch <= '0;
            for (int k = 0; k < I; k++) r_ptr[k] <= '0;
        end else if (!intlv_out_sync) begin
            r_br     <= '0;
            r_fill   <= '0;
            r_vld    <= 1'b0;
            r_pass   <= 1'b0;
            r_byte   <= '0;
            r_branch <= '0;
            for (int k = 0; k < I; k++) r_ptr[k] <= '0;
        end else begin
            r_br     <= w_pass ? '0 : r_br + 1'b1;
            if (!w_pass) r_ptr[r_br] <= (r_ptr[r_br] == w_last[r_br]) ? '0 : r_ptr[r_br] + 1'b1;
            r_fill   <= (r_fill == FW'(L)) ? r_fill : r_fill + 1'b1;
            r_vld    <= r_fill == FW'(L);
            r_pass   <= w_pass;
            r_byte   <= intlv_out_err;
            r_branch <= r_br;
        end
    end

    assign deintlv_out       = r_vld ? (r_pass ? r_byte : w_q) : '0;
    assign deintlv_out_valid = r_vld;
    assign deintlv_branch    = r_branch;
endmodule

// File: tb/tb_conv_deinterleaver.sv
// tb_conv_deinterleaver: interleaver model drives default and small (I=4, M=3) deinterleavers,
// checking order, fill latency, burst spreading, sync-drop refill and reset behaviour.
module tb_conv_deinterleaver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d_in = '0;
    logic       sync = 1'b0;
    logic [7:0] d_out;
    logic       vld;
    logic [3:0] br;
    logic [7:0] s_in = '0;
    logic       s_sync = 1'b0;
    logic [7:0] s_out;
    logic       s_vld;
    logic [1:0] s_br;
    logic [7:0] src [10000];
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    conv_deinterleaver u_dut (
        .clk_out125M       (clk),
        .sys_rst           (rst),
        .intlv_out_err     (d_in),
        .intlv_out_sync    (sync),
        .deintlv_out       (d_out),
        .deintlv_out_valid (vld),
        .deintlv_branch    (br)
    );

    conv_deinterleaver #(.I(4), .M(3), .DW(8)) u_small (
        .clk_out125M       (clk),
        .sys_rst           (rst),
        .intlv_out_err     (s_in),
        .intlv_out_sync    (s_sync),
        .deintlv_out       (s_out),
        .deintlv_out_valid (s_vld),
        .deintlv_branch    (s_br)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, vld, 0);
        chk({tag, "_data"}, d_out, 0);
        chk({tag, "_branch"}, br, 0);
    endtask

    // Interleaver model: branch j of stream index t carries src[t - j*M*I] (zero before history).
    // Deinterleaved output of accepted byte t must equal src[t - L] once t >= L.
    task automatic run_stream(input bit sm, input int n, input bit burst);
        int ii, mm, ll, j, s, ov, od, ob, ed;
        logic [7:0] b;
        ii = sm ? 4 : 12;
        mm = sm ? 3 : 17;
        ll = mm * ii * (ii - 1);
        for (int t = 0; t < n; t++) begin
            j = t % ii;
            s = t - j * mm * ii;
            b = (s >= 0) ? src[s] : 8'd0;
            if (burst && t >= 2400 && t < 2412) b = 8'd0;
            @(negedge clk);
            sync   = !sm;
            d_in   = sm ? 8'd0 : b;
            s_sync = sm;
            s_in   = sm ? b : 8'd0;
            @(posedge clk);
            #1;
            ov = sm ? int'(s_vld) : int'(vld);
            od = sm ? int'(s_out) : int'(d_out);
            ob = sm ? int'(s_br) : int'(br);
            ed = (t >= ll) ? int'(src[t - ll]) : 0;
            if (burst && t >= 2411 && t <= 4644 && (t - 2411) % 203 == 0) ed = 0;
            chk($sformatf("valid@%0d", t), ov, int'(t >= ll));
            chk($sformatf("data@%0d", t), od, ed);
            chk($sformatf("branch@%0d", t), ob, j);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 chk_idle($sformatf("post_rst%0d", k));
        end
        for (int k = 0; k < 10000; k++) src[k] = 8'(k);
        run_stream(1'b0, 5000, 1'b1);
        @(negedge clk);
        sync = 1'b0;
        @(posedge clk);
        #1 chk_idle("sync_drop");
        for (int k = 0; k < 10000; k++) src[k] = 8'($urandom);
        run_stream(1'b0, 8000, 1'b0);
        chk("pre_rst_valid", vld, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_idle("async_rst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sync = 1'b1;
            d_in = 8'hA5;
            @(posedge clk);
            #1 chk_idle($sformatf("in_rst%0d", k));
        end
        @(negedge clk);
        sync = 1'b0;
        rst  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 chk_idle($sformatf("rst_rel%0d", k));
        end
        for (int k = 0; k < 10000; k++) src[k] = 8'(k + 7);
        run_stream(1'b1, 200, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
